// File: rtl/sextium_io_port_if.sv
// rtl/sextium_io_port_if.sv - core request/ack and host stream signals of the Sextium I/O port
interface sextium_io_port_if;
    logic        io_read;
    logic        io_write;
    logic        ioack;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        proto_err;

    modport slave (
        input  io_read, io_write, in_valid, in_data, out_ready,
        output ioack, in_ready, out_valid, out_data, proto_err
    );

    modport master (
        output io_read, io_write, in_valid, in_data, out_ready,
        input  ioack, in_ready, out_valid, out_data, proto_err
    );
endinterface

// File: rtl/sextium_io_port.sv
// rtl/sextium_io_port.sv - Sextium core I/O port with host-side input and output FIFOs
module sextium_io_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [15:0]      io_bus,
    sextium_io_port_if.slave port
);
    typedef enum logic [1:0] {IDLE, RD_ACK, WR_ACK, RELEASE} state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic          proto_err_q, proto_err_d;

    logic [15:0]   in_mem_q [DEPTH];
    logic [AW-1:0] in_wr_ptr_q, in_rd_ptr_q;
    logic [AW:0]   in_count_q;
    logic [15:0]   out_mem_q [DEPTH];
    logic [AW-1:0] out_wr_ptr_q, out_rd_ptr_q;
    logic [AW:0]   out_count_q;

    logic in_full, in_empty, in_push, in_pop;
    logic out_full, out_empty, out_push, out_pop;

    assign in_full   = (in_count_q == FULL_COUNT);
    assign in_empty  = (in_count_q == '0);
    assign out_full  = (out_count_q == FULL_COUNT);
    assign out_empty = (out_count_q == '0);

    // Ready is derived from the registered count only, so a same-cycle pop never admits a push into a full FIFO.
    assign in_push = port.in_valid && !in_full;
    assign in_pop  = (state_q == RD_ACK);
    assign out_pop = !out_empty && port.out_ready;

    // Request arbitration: conflicting requests are flagged and never acked; a full/empty FIFO stalls the core.
    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        out_push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (port.io_read && port.io_write) begin
                    proto_err_d = 1'b1;
                end else if (port.io_write && !out_full) begin
                    out_push = 1'b1;
                    state_d  = WR_ACK;
                end else if (port.io_read && !in_empty) begin
                    state_d = RD_ACK;
                end
            end
            RD_ACK:  state_d = RELEASE;
            WR_ACK:  state_d = RELEASE;
            RELEASE: if (!port.io_read && !port.io_write) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and sticky error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Input FIFO pointers and occupancy; host pushes, the read ack pops.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_wr_ptr_q <= '0;
            in_rd_ptr_q <= '0;
            in_count_q  <= '0;
        end else begin
            if (in_push) in_wr_ptr_q <= in_wr_ptr_q + 1'b1;
            if (in_pop)  in_rd_ptr_q <= in_rd_ptr_q + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count_q <= in_count_q + 1'b1;
                2'b01:   in_count_q <= in_count_q - 1'b1;
                default: in_count_q <= in_count_q;
            endcase
        end
    end

    // Output FIFO pointers and occupancy; core writes push, the host pops.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
        end else begin
            if (out_push) out_wr_ptr_q <= out_wr_ptr_q + 1'b1;
            if (out_pop)  out_rd_ptr_q <= out_rd_ptr_q + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_count_q <= out_count_q + 1'b1;
                2'b01:   out_count_q <= out_count_q - 1'b1;
                default: out_count_q <= out_count_q;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (in_push)  in_mem_q[in_wr_ptr_q]   <= port.in_data;
        if (out_push) out_mem_q[out_wr_ptr_q] <= io_bus;
    end

    // Ack and bus drive come from state alone, so no request input reaches them combinationally.
    assign port.ioack     = (state_q == RD_ACK) || (state_q == WR_ACK);
    assign io_bus         = (state_q == RD_ACK) ? in_mem_q[in_rd_ptr_q] : 16'bz;
    assign port.in_ready  = !in_full;
    assign port.out_valid = !out_empty;
    assign port.out_data  = out_mem_q[out_rd_ptr_q];
    assign port.proto_err = proto_err_q;
endmodule

// File: tb/tb_sextium_io_port.sv
// tb/tb_sextium_io_port.sv - scoreboard bench for sextium_io_port
module tb_sextium_io_port;
    logic        clock = 1'b0;
    logic        reset;
    wire  [15:0] io_bus;
    logic        tb_drive;
    logic [15:0] tb_data;

    assign io_bus = tb_drive ? tb_data : 16'bz;

    sextium_io_port_if bus_if();

    sextium_io_port #(.DEPTH(4), .AW(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (io_bus),
        .port   (bus_if)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int          at;
    } ack_t;

    ack_t        ack_q[$];
    logic [15:0] out_q[$];
    ack_t        mon_e;
    logic [15:0] mon_w;
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ack monitor: every ack must match the oldest expected response, including its cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus_if.ioack) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: ioack=1 at cycle %0d, required 0", cyc);
                end else begin
                    mon_e = ack_q.pop_front();
                    check_int("ack_cycle", cyc, mon_e.at);
                    if (mon_e.is_rd) check16("rd_data", io_bus, mon_e.data);
                end
            end else if (!tb_drive) begin
                checks++;
                if (!(io_bus === 16'hzzzz || io_bus === 16'h0000)) begin
                    failures++;
                    $display("FAIL bus_idle: io_bus=%h at cycle %0d, required Z", io_bus, cyc);
                end
            end
        end
    end

    // Output stream monitor: every host pop must deliver the next expected core word.
    always @(negedge clock) begin
        if (mon_en && bus_if.out_valid && bus_if.out_ready) begin
            if (out_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: out_data=%h at cycle %0d, required none", bus_if.out_data, cyc);
            end else begin
                mon_w = out_q.pop_front();
                check16("out_data", bus_if.out_data, mon_w);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clock);
            if (bus_if.ioack) break;
            n++;
        end
        if (n == 50) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: ioack=0 after 50 cycles, required 1", name);
        end
    endtask

    task automatic core_write(input logic [15:0] d);
        bus_if.io_write = 1'b1;
        tb_drive        = 1'b1;
        tb_data         = d;
        ack_q.push_back('{1'b0, d, cyc + 1});
        out_q.push_back(d);
        wait_ack("write");
        tick();
        bus_if.io_write = 1'b0;
        tb_drive        = 1'b0;
        tick();
    endtask

    task automatic core_read(input logic [15:0] d);
        bus_if.io_read = 1'b1;
        ack_q.push_back('{1'b1, d, cyc + 1});
        wait_ack("read");
        tick();
        bus_if.io_read = 1'b0;
        tick();
    endtask

    task automatic host_push(input logic [15:0] d);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus_if.out_ready = 1'b1;
        repeat (n) tick();
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        tb_drive         = 1'b0;
        tb_data          = 16'h0000;
        bus_if.io_read   = 1'b0;
        bus_if.io_write  = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 16'h0000;
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check16("reset_ioack", 16'(bus_if.ioack), 16'h0);
        check16("reset_in_ready", 16'(bus_if.in_ready), 16'h1);
        check16("reset_out_valid", 16'(bus_if.out_valid), 16'h0);
        check16("reset_proto_err", 16'(bus_if.proto_err), 16'h0);
        mon_en = 1'b1;

        // Write path: request held two cycles, ack in the second, word visible from the ack cycle.
        bus_if.io_write = 1'b1;
        tb_drive        = 1'b1;
        tb_data         = 16'h1234;
        ack_q.push_back('{1'b0, 16'h1234, cyc + 1});
        out_q.push_back(16'h1234);
        wait_ack("write_path");
        check16("wr_out_valid", 16'(bus_if.out_valid), 16'h1);
        check16("wr_out_data", bus_if.out_data, 16'h1234);
        tick();
        bus_if.io_write = 1'b0;
        tb_drive        = 1'b0;
        tick();
        check16("wr_out_valid_hold", 16'(bus_if.out_valid), 16'h1);
        drain(1);
        check16("wr_out_drained", 16'(bus_if.out_valid), 16'h0);

        // Read path: two host words returned in order.
        host_push(16'hBEEF);
        host_push(16'h0042);
        core_read(16'hBEEF);
        core_read(16'h0042);

        // Read from empty: stall 10 cycles, host word arrives, ack two cycles after the push cycle.
        bus_if.io_read = 1'b1;
        ack_q.push_back('{1'b1, 16'h0007, cyc + 12});
        repeat (10) tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 16'h0007;
        tick();
        bus_if.in_valid = 1'b0;
        wait_ack("read_empty");
        tick();
        bus_if.io_read = 1'b0;
        tick();

        // Output full: four writes fill it, the fifth stalls until the host pops one word.
        for (int i = 1; i <= 4; i++) core_write(16'(i));
        check16("outfull_valid", 16'(bus_if.out_valid), 16'h1);
        bus_if.io_write = 1'b1;
        tb_drive        = 1'b1;
        tb_data         = 16'h0005;
        repeat (3) tick();
        bus_if.out_ready = 1'b1;
        ack_q.push_back('{1'b0, 16'h0005, cyc + 2});
        out_q.push_back(16'h0005);
        tick();
        bus_if.out_ready = 1'b0;
        wait_ack("write_full");
        tick();
        bus_if.io_write = 1'b0;
        tb_drive        = 1'b0;
        tick();
        drain(4);
        check16("outfull_drained", 16'(bus_if.out_valid), 16'h0);

        // Full input FIFO: host push in the read-ack cycle is refused, count drops to 3.
        for (int i = 1; i <= 4; i++) host_push(16'hA000 + 16'(i));
        check16("infull_ready", 16'(bus_if.in_ready), 16'h0);
        bus_if.io_read = 1'b1;
        ack_q.push_back('{1'b1, 16'hA001, cyc + 1});
        tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 16'hEEEE;
        check16("pushpop_ready", 16'(bus_if.in_ready), 16'h0);
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.io_read  = 1'b0;
        check16("after_pop_ready", 16'(bus_if.in_ready), 16'h1);
        tick();
        core_read(16'hA002);
        core_read(16'hA003);
        core_read(16'hA004);
        host_push(16'h5A5A);
        core_read(16'h5A5A);

        // Protocol error: both requests for three cycles, no ack, sticky flag, nothing written.
        bus_if.io_read  = 1'b1;
        bus_if.io_write = 1'b1;
        tb_drive        = 1'b1;
        tb_data         = 16'hDEAD;
        repeat (3) tick();
        bus_if.io_read  = 1'b0;
        bus_if.io_write = 1'b0;
        tb_drive        = 1'b0;
        tick();
        check16("proto_err_set", 16'(bus_if.proto_err), 16'h1);
        check16("proto_no_write", 16'(bus_if.out_valid), 16'h0);
        repeat (3) tick();
        check16("proto_err_sticky", 16'(bus_if.proto_err), 16'h1);

        // Reset during RD_ACK: everything cleared, leftover input word discarded.
        core_write(16'h7777);
        host_push(16'h1111);
        host_push(16'h2222);
        bus_if.io_read = 1'b1;
        ack_q.push_back('{1'b1, 16'h1111, cyc + 1});
        tick();
        reset          = 1'b1;
        bus_if.io_read = 1'b0;
        tick();
        reset = 1'b0;
        out_q.delete();
        check16("rst_ioack", 16'(bus_if.ioack), 16'h0);
        check16("rst_proto_err", 16'(bus_if.proto_err), 16'h0);
        check16("rst_out_valid", 16'(bus_if.out_valid), 16'h0);
        check16("rst_in_ready", 16'(bus_if.in_ready), 16'h1);
        bus_if.io_read = 1'b1;
        ack_q.push_back('{1'b1, 16'h3333, cyc + 3});
        tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 16'h3333;
        tick();
        bus_if.in_valid = 1'b0;
        wait_ack("read_after_reset");
        tick();
        bus_if.io_read = 1'b0;
        repeat (3) tick();

        check_int("ack_queue_empty", ack_q.size(), 0);
        check_int("out_queue_empty", out_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
